// File: rtl/exec_stage.sv
// Execute stage: operand select/forwarding, ALU, branch resolve; 1-cycle accept-to-result.
// Backpressure: in_ready = !out_valid || out_ready; all outputs hold while stalled.

module exec_alu (
    input  logic [2:0]  funct3_i,
    input  logic        is_branch_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] result_o,
    output logic        taken_o
);
    logic slt;
    logic seq;
    logic nz_diff;

    assign slt     = $signed(src1_i) < $signed(src2_i);
    assign seq     = src1_i == src2_i;
    assign nz_diff = (src1_i != 32'd0) ^ (src2_i != 32'd0);

    always_comb begin
        result_o = src1_i ^ src2_i;
        taken_o  = 1'b0;
        if (is_branch_i) begin
            case (funct3_i)
                3'b000:  taken_o = seq;
                3'b001:  taken_o = !seq;
                3'b010:  taken_o = nz_diff;
                3'b011:  taken_o = !nz_diff;
                3'b100:  taken_o = slt;
                3'b101:  taken_o = !slt;
                3'b110:  taken_o = !slt && !seq;
                default: taken_o = slt || seq;
            endcase
        end else begin
            case (funct3_i)
                3'b000:  result_o = src1_i + src2_i;
                3'b001:  result_o = slt ? src1_i : src2_i;
                3'b010:  result_o = src1_i << src2_i[4:0];
                3'b011:  result_o = slt ? src2_i : src1_i;
                default: result_o = src1_i ^ src2_i;
            endcase
        end
    end
endmodule

module exec_stage #(
    parameter int FWD_EN    = 1,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [31:0]          in_rs1_val,
    input  logic [31:0]          in_rs2_val,
    input  logic [31:0]          in_imm,
    input  logic                 in_use_imm,
    input  logic [2:0]           in_funct3,
    input  logic                 in_is_branch,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_wen,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_wen,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc
);
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_result_q, out_result_d;
    logic [REG_IDX_W-1:0] out_rd_q, out_rd_d;
    logic                 out_wen_q, out_wen_d;
    logic                 redirect_valid_q, redirect_valid_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;

    logic        accept;
    logic        load;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_result;
    logic        taken;
    logic [31:0] target;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // An accept during the redirect cycle is wrong-path and must not load.
    assign load     = accept && !redirect_valid_q;

    assign fwd1_hit = (FWD_EN != 0) && out_valid_q && out_wen_q
                      && (out_rd_q == in_rs1_idx) && (in_rs1_idx != '0);
    assign fwd2_hit = (FWD_EN != 0) && out_valid_q && out_wen_q
                      && (out_rd_q == in_rs2_idx) && (in_rs2_idx != '0);

    assign src1   = fwd1_hit ? out_result_q : in_rs1_val;
    assign src2   = (in_use_imm && !in_is_branch) ? in_imm
                  : (fwd2_hit ? out_result_q : in_rs2_val);
    assign target = in_pc + in_imm;

    exec_alu u_alu (
        .funct3_i    (in_funct3),
        .is_branch_i (in_is_branch),
        .src1_i      (src1),
        .src2_i      (src2),
        .result_o    (alu_result),
        .taken_o     (taken)
    );

    always_comb begin
        out_valid_d      = out_valid_q;
        out_result_d     = out_result_q;
        out_rd_d         = out_rd_q;
        out_wen_d        = out_wen_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_result_d = in_is_branch ? 32'd0 : alu_result;
            out_rd_d     = in_rd;
            out_wen_d    = in_wen && !in_is_branch;
            if (in_is_branch && taken) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            out_result_q     <= 32'd0;
            out_rd_q         <= '0;
            out_wen_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_result_q     <= out_result_d;
            out_rd_q         <= out_rd_d;
            out_wen_q        <= out_wen_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_rd         = out_rd_q;
    assign out_wen        = out_wen_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: forwarding (index 0) and non-forwarding (index 1) instances
// share one stimulus; a transaction-level model plus literal expectations check both.

module tb_exec_stage;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1_idx;
    logic [4:0]  in_rs2_idx;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [2:0]  in_funct3;
    logic        in_is_branch;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_ready;

    logic        d_irdy[2];
    logic        d_ov[2];
    logic [31:0] d_res[2];
    logic [4:0]  d_rd[2];
    logic        d_wen[2];
    logic        d_rv[2];
    logic [31:0] d_rpc[2];

    int checks = 0;
    int errors = 0;

    exec_stage #(.FWD_EN(1), .REG_IDX_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_irdy[0]),
        .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_funct3(in_funct3), .in_is_branch(in_is_branch),
        .in_rd(in_rd), .in_wen(in_wen), .out_valid(d_ov[0]), .out_ready(out_ready),
        .out_result(d_res[0]), .out_rd(d_rd[0]), .out_wen(d_wen[0]),
        .redirect_valid(d_rv[0]), .redirect_pc(d_rpc[0])
    );

    exec_stage #(.FWD_EN(0), .REG_IDX_W(5)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_irdy[1]),
        .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_funct3(in_funct3), .in_is_branch(in_is_branch),
        .in_rd(in_rd), .in_wen(in_wen), .out_valid(d_ov[1]), .out_ready(out_ready),
        .out_result(d_res[1]), .out_rd(d_rd[1]), .out_wen(d_wen[1]),
        .redirect_valid(d_rv[1]), .redirect_pc(d_rpc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics: returns {taken, result}.
    function automatic logic [32:0] ref_exec(input logic [2:0] f3, input logic br,
                                             input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic t;
        logic [31:0] r;
        sa = a;
        sb = b;
        t = 1'b0;
        r = 32'd0;
        if (br) begin
            case (f3)
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd2: t = (a != 0) != (b != 0);
                3'd3: t = (a != 0) == (b != 0);
                3'd4: t = sa < sb;
                3'd5: t = sa >= sb;
                3'd6: t = sa > sb;
                default: t = sa <= sb;
            endcase
        end else begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = (sa < sb) ? a : b;
                3'd2: r = a << b[4:0];
                3'd3: r = (sa > sb) ? a : b;
                default: r = a ^ b;
            endcase
        end
        return {t, r};
    endfunction

    logic        m_v[2];
    logic [31:0] m_res[2];
    logic [4:0]  m_rd[2];
    logic        m_w[2];
    logic        m_rv[2];
    logic [31:0] m_rpc[2];

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] r;
        logic        acc;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_v[k] <= 1'b0; m_res[k] <= 32'd0; m_rd[k] <= 5'd0;
                m_w[k] <= 1'b0; m_rv[k] <= 1'b0; m_rpc[k] <= 32'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                acc = in_valid && (!m_v[k] || out_ready);
                a = in_rs1_val;
                b = in_rs2_val;
                if (k == 0 && m_v[k] && m_w[k] && in_rs1_idx != 0 && m_rd[k] == in_rs1_idx)
                    a = m_res[k];
                if (k == 0 && m_v[k] && m_w[k] && in_rs2_idx != 0 && m_rd[k] == in_rs2_idx)
                    b = m_res[k];
                if (in_use_imm && !in_is_branch)
                    b = in_imm;
                r = ref_exec(in_funct3, in_is_branch, a, b);
                m_rv[k] <= 1'b0;
                if (acc && !m_rv[k]) begin
                    m_v[k]   <= 1'b1;
                    m_res[k] <= in_is_branch ? 32'd0 : r[31:0];
                    m_rd[k]  <= in_rd;
                    m_w[k]   <= in_is_branch ? 1'b0 : in_wen;
                    if (in_is_branch && r[32]) begin
                        m_rv[k]  <= 1'b1;
                        m_rpc[k] <= in_pc + in_imm;
                    end
                end else if (m_v[k] && out_ready) begin
                    m_v[k] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cyc_out_valid[%0d]", k), 32'(d_ov[k]), 32'(m_v[k]));
                chk($sformatf("cyc_out_result[%0d]", k), d_res[k], m_res[k]);
                chk($sformatf("cyc_out_rd[%0d]", k), 32'(d_rd[k]), 32'(m_rd[k]));
                chk($sformatf("cyc_out_wen[%0d]", k), 32'(d_wen[k]), 32'(m_w[k]));
                chk($sformatf("cyc_redirect_valid[%0d]", k), 32'(d_rv[k]), 32'(m_rv[k]));
                chk($sformatf("cyc_redirect_pc[%0d]", k), d_rpc[k], m_rpc[k]);
                chk($sformatf("cyc_in_ready[%0d]", k), 32'(d_irdy[k]), 32'(!m_v[k] || out_ready));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] i1, input logic [4:0] i2,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic ui, input logic [2:0] f3, input logic br,
                         input logic [4:0] rd, input logic w);
        in_valid = 1'b1; in_pc = pc; in_rs1_idx = i1; in_rs2_idx = i2;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_use_imm = ui;
        in_funct3 = f3; in_is_branch = br; in_rd = rd; in_wen = w;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    logic [2:0]  alu_f3[6]  = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd2, 3'd7};
    logic [31:0] alu_a[6]   = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h000000F0, 32'h12345678, 32'h00000001, 32'hFFFF0000};
    logic [31:0] alu_b[6]   = '{32'h2, 32'h2, 32'h0F, 32'hFFFFFFFF, 32'h00000021, 32'h0000FFFF};
    logic [31:0] alu_exp[6] = '{32'hFFFFFFFD, 32'h2, 32'hFF, 32'hEDCBA987, 32'h2, 32'hFFFFFFFF};
    logic        br_exp[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b0; out_ready = 1'b1;
        idle();
        drive(32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_out_valid", 32'(d_ov[0]), 32'd0);
        chk("reset_redirect_pc", d_rpc[0], 32'd0);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        drive(32'h40, 5'd1, 5'd0, 32'd9, 32'd0, 32'd1, 1'b1, 3'd0, 1'b0, 5'd2, 1'b1);
        tick();
        idle();
        tick();
        chk("stall_out_valid", 32'(d_ov[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(d_ov[0]), 32'd0);
        chk("midrst_redirect", 32'(d_rv[0]), 32'd0);
        chk("midrst_in_ready", 32'(d_irdy[0]), 32'd1);
        tick();
        rst = 1'b0; out_ready = 1'b1;

        // add rs1=5, imm=-7
        drive(32'h44, 5'd1, 5'd0, 32'd5, 32'd0, 32'hFFFFFFF9, 1'b1, 3'd0, 1'b0, 5'd3, 1'b1);
        tick();
        idle();
        chk("add_result", d_res[0], 32'hFFFFFFFE);
        chk("add_rd", 32'(d_rd[0]), 32'd3);
        chk("add_wen", 32'(d_wen[0]), 32'd1);

        // Dependency x4 -> sll; then rd=0 producer is never forwarded.
        drive(32'h48, 5'd0, 5'd0, 32'h10, 32'd0, 32'd0, 1'b1, 3'd0, 1'b0, 5'd4, 1'b1);
        tick();
        drive(32'h4C, 5'd4, 5'd5, 32'd0, 32'd2, 32'd0, 1'b0, 3'd2, 1'b0, 5'd6, 1'b1);
        tick();
        idle();
        chk("fwd_sll", d_res[0], 32'h40);
        chk("nofwd_sll", d_res[1], 32'h0);
        drive(32'h50, 5'd0, 5'd0, 32'h10, 32'd0, 32'd0, 1'b1, 3'd0, 1'b0, 5'd0, 1'b1);
        tick();
        chk("rd0_wen", 32'(d_wen[0]), 32'd1);
        chk("rd0_result", d_res[0], 32'h10);
        drive(32'h54, 5'd0, 5'd5, 32'd0, 32'd2, 32'd0, 1'b0, 3'd2, 1'b0, 5'd6, 1'b1);
        tick();
        idle();
        chk("rd0_not_fwd", d_res[0], 32'h0);

        // ALU op table, back to back.
        for (int i = 0; i < 6; i++) begin
            drive(32'h60, 5'd11, 5'd12, alu_a[i], alu_b[i], 32'd0, 1'b0, alu_f3[i], 1'b0, 5'd10, 1'b1);
            tick();
            chk($sformatf("alu_vec%0d", i), d_res[0], alu_exp[i]);
        end
        idle();
        tick();

        // blt taken, following instruction is killed.
        drive(32'h100, 5'd7, 5'd8, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b0, 3'd4, 1'b1, 5'd9, 1'b1);
        tick();
        chk("blt_redirect", 32'(d_rv[0]), 32'd1);
        chk("blt_pc", d_rpc[0], 32'h120);
        chk("blt_wen", 32'(d_wen[0]), 32'd0);
        drive(32'h104, 5'd1, 5'd0, 32'd3, 32'd0, 32'd4, 1'b1, 3'd0, 1'b0, 5'd9, 1'b1);
        tick();
        idle();
        chk("kill_out_valid", 32'(d_ov[0]), 32'd0);
        chk("kill_redirect", 32'(d_rv[0]), 32'd0);

        // beq wrapping target, then bne not taken.
        drive(32'hFFFFFFF0, 5'd7, 5'd8, 32'd7, 32'd7, 32'h20, 1'b0, 3'd0, 1'b1, 5'd0, 1'b0);
        tick();
        idle();
        chk("beq_wrap_pc", d_rpc[0], 32'h10);
        tick();
        drive(32'hFFFFFFF0, 5'd7, 5'd8, 32'd7, 32'd7, 32'h40, 1'b0, 3'd1, 1'b1, 5'd0, 1'b0);
        tick();
        idle();
        chk("bne_no_redirect", 32'(d_rv[0]), 32'd0);
        chk("bne_pc_hold", d_rpc[0], 32'h10);

        // Branch condition table with src1=5, src2=0.
        for (int c = 0; c < 8; c++) begin
            drive(32'h300, 5'd1, 5'd2, 32'd5, 32'd0, 32'h10, 1'b0, 3'(c), 1'b1, 5'd0, 1'b0);
            tick();
            idle();
            chk($sformatf("br_cond%0d", c), 32'(d_rv[0]), 32'(br_exp[c]));
            tick();
        end

        // Taken branch stalled 3 cycles: single redirect pulse, stable outputs.
        out_ready = 1'b0;
        drive(32'h200, 5'd1, 5'd2, 32'd3, 32'd3, 32'h8, 1'b0, 3'd0, 1'b1, 5'd0, 1'b0);
        tick();
        drive(32'h204, 5'd1, 5'd0, 32'd3, 32'd0, 32'd4, 1'b1, 3'd0, 1'b0, 5'd13, 1'b1);
        chk("stall_br_pulse", 32'(d_rv[0]), 32'd1);
        chk("stall_br_pc", d_rpc[0], 32'h208);
        chk("stall_in_ready", 32'(d_irdy[0]), 32'd0);
        repeat (2) begin
            tick();
            chk("stall_no_repeat", 32'(d_rv[0]), 32'd0);
            chk("stall_hold_valid", 32'(d_ov[0]), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", 32'(d_irdy[0]), 32'd1);
        tick();
        idle();
        chk("after_stall_result", d_res[0], 32'd7);
        chk("after_stall_valid", 32'(d_ov[0]), 32'd1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
